mem_stage: RTL

- MEM stage of the 5-stage CPU; consumes the EX/MEM pipeline register outputs and produces the MEM/WB register contents.
- Contains a 32x32 local data memory.
- Sequences multi-cycle sprite-memory accesses over a req/ack handshake and stalls the pipeline while an access is in flight.
- Resolves branches from the latched flags, redirecting the PC and flushing upstream stages.

---
 rtl/cpu_pkg.sv | 45 ++++
 rtl/mem_data_ram.sv | 25 ++
 rtl/mem_stage.sv | 138 +++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared CPU constants, branch codes and MEM-stage FSM encoding
package cpu_pkg;

  localparam int DATA_W      = 32;
  localparam int PC_W        = 22;
  localparam int SPR_ADDR_W  = 16;
  localparam int DMEM_DEPTH  = 32;
  localparam int DMEM_ADDR_W = 5;

  localparam logic [2:0] BR_NONE   = 3'b000;
  localparam logic [2:0] BR_EQ     = 3'b001;
  localparam logic [2:0] BR_NE     = 3'b010;
  localparam logic [2:0] BR_GT     = 3'b011;
  localparam logic [2:0] BR_LT     = 3'b100;
  localparam logic [2:0] BR_GE     = 3'b101;
  localparam logic [2:0] BR_OV     = 3'b110;
  localparam logic [2:0] BR_ALWAYS = 3'b111;

  typedef enum logic [1:0] {
    SPR_IDLE = 2'd0,
    SPR_REQ  = 2'd1,
    SPR_DONE = 2'd2
  } spr_state_t;

  function automatic logic branch_cond_true(input logic [2:0] cond,
                                            input logic       v,
                                            input logic       n,
                                            input logic       z);
    logic t;
    t = 1'b0;
    case (cond)
      BR_NONE:   t = 1'b0;
      BR_EQ:     t = z;
      BR_NE:     t = ~z;
      BR_GT:     t = ~z & ~n;
      BR_LT:     t = n;
      BR_GE:     t = ~n;
      BR_OV:     t = v;
      BR_ALWAYS: t = 1'b1;
      default:   t = 1'b0;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/mem_data_ram.sv
// rtl/mem_data_ram.sv - local data memory, asynchronous read, synchronous write
module mem_data_ram #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Read sees the pre-edge contents, so a same-cycle write returns the old word.
  assign rdata = mem[addr];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
  end

endmodule

// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - MEM pipeline stage: data memory, sprite-memory sequencer, branch resolution
module mem_stage
  import cpu_pkg::*;
#(
  parameter int DATA_W     = cpu_pkg::DATA_W,
  parameter int PC_W       = cpu_pkg::PC_W,
  parameter int SPR_ADDR_W = cpu_pkg::SPR_ADDR_W
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  MEM_re,
  input  logic                  MEM_we,
  input  logic                  MEM_mem_ALU_select,
  input  logic                  MEM_use_sprite_mem,
  input  logic                  MEM_use_dst_reg,
  input  logic                  MEM_hlt,
  input  logic                  MEM_flag_ov,
  input  logic                  MEM_flag_neg,
  input  logic                  MEM_flag_zero,
  input  logic [2:0]            MEM_branch_cond,
  input  logic [4:0]            MEM_addr,
  input  logic [4:0]            MEM_dst_reg,
  input  logic [PC_W-1:0]       MEM_PC,
  input  logic [PC_W-1:0]       MEM_PC_out,
  input  logic [DATA_W-1:0]     MEM_data,
  input  logic [DATA_W-1:0]     MEM_sprite_data,
  input  logic [DATA_W-1:0]     MEM_ALU_result,
  output logic                  spr_req,
  output logic                  spr_we,
  output logic [SPR_ADDR_W-1:0] spr_addr,
  output logic [DATA_W-1:0]     spr_wdata,
  input  logic                  spr_ack,
  input  logic [DATA_W-1:0]     spr_rdata,
  output logic                  mem_stall,
  output logic                  branch_taken,
  output logic [PC_W-1:0]       branch_target,
  output logic                  WB_use_dst_reg,
  output logic [4:0]            WB_dst_reg,
  output logic [DATA_W-1:0]     WB_data,
  output logic [PC_W-1:0]       WB_PC,
  output logic                  WB_hlt
);

  spr_state_t        state;
  logic              spr_acc;
  logic              cond_true;
  logic              dmem_we;
  logic [DATA_W-1:0] dmem_rdata;
  logic [DATA_W-1:0] spr_rdata_q;
  logic [DATA_W-1:0] wb_data_nxt;

  assign spr_acc   = MEM_use_sprite_mem & (MEM_re | MEM_we);
  // The instruction is released in DONE, when the captured sprite data is ready.
  assign mem_stall = spr_acc & (state != SPR_DONE);

  assign cond_true     = branch_cond_true(MEM_branch_cond, MEM_flag_ov, MEM_flag_neg, MEM_flag_zero);
  assign branch_taken  = cond_true & ~mem_stall & ~WB_hlt;
  assign branch_target = MEM_PC_out;

  assign dmem_we = MEM_we & ~MEM_use_sprite_mem & ~mem_stall & ~WB_hlt;

  mem_data_ram #(
    .DATA_W(DATA_W),
    .DEPTH (DMEM_DEPTH),
    .ADDR_W(DMEM_ADDR_W)
  ) u_dmem (
    .clk  (clk),
    .we   (dmem_we),
    .addr (MEM_addr),
    .wdata(MEM_data),
    .rdata(dmem_rdata)
  );

  always_comb begin
    wb_data_nxt = MEM_ALU_result;
    if (MEM_use_sprite_mem & MEM_re) begin
      wb_data_nxt = spr_rdata_q;
    end else if (MEM_mem_ALU_select & MEM_re) begin
      wb_data_nxt = dmem_rdata;
    end
  end

  // Address and write data are captured on entry to REQ and held for the whole access.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= SPR_IDLE;
      spr_req     <= 1'b0;
      spr_we      <= 1'b0;
      spr_addr    <= '0;
      spr_wdata   <= '0;
      spr_rdata_q <= '0;
    end else if (!WB_hlt) begin
      case (state)
        SPR_IDLE: begin
          if (spr_acc) begin
            state     <= SPR_REQ;
            spr_req   <= 1'b1;
            spr_we    <= MEM_we;
            spr_addr  <= MEM_ALU_result[SPR_ADDR_W-1:0];
            spr_wdata <= MEM_sprite_data;
          end
        end
        SPR_REQ: begin
          if (spr_ack) begin
            state       <= SPR_DONE;
            spr_req     <= 1'b0;
            spr_we      <= 1'b0;
            spr_rdata_q <= spr_rdata;
          end
        end
        SPR_DONE: state <= SPR_IDLE;
        default:  state <= SPR_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      WB_use_dst_reg <= 1'b0;
      WB_dst_reg     <= '0;
      WB_data        <= '0;
      WB_PC          <= '0;
      WB_hlt         <= 1'b0;
    end else if (!WB_hlt) begin
      if (mem_stall) begin
        WB_use_dst_reg <= 1'b0;
        WB_hlt         <= 1'b0;
      end else begin
        WB_use_dst_reg <= MEM_use_dst_reg;
        WB_dst_reg     <= MEM_dst_reg;
        WB_data        <= wb_data_nxt;
        WB_PC          <= MEM_PC;
        WB_hlt         <= MEM_hlt;
      end
    end
  end

endmodule
